count_display_driver: RTL and testbench

COUNT_DISPLAY_DRIVER -- requirements
Module: count_display_driver

---
 rtl/count_display_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 15 +
 rtl/count_display_driver.sv | 129 ++++++++++++
 tb/tb_count_display_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared types and constants for the count display driver: FSM states,
// scan digit indices, active-high 7-segment font and the double-dabble step.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIG_ONES  = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNDS = 2'd2
  } digit_t;

  localparam int unsigned CONV_STEPS = 8;

  // Bit order {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [6:0] SEG_PAT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Add-3 correction applied to every BCD nibble before each shift.
  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern; blank or non-decimal input is unlit.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = '0;
    if (!blank && digit <= 4'd9) pattern = SEG_PAT[digit];
  end

endmodule

// File: rtl/count_display_driver.sv
// Converts an 8-bit count to BCD by double-dabble and scans three
// leading-zero-blanked 7-segment digits.
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] count_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_PAT[0] : SEG_PAT[0];

  state_t      state;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  step;
  logic [3:0]  dig_h, dig_t, dig_o;

  assign busy = (state == CONV) || (state == UPDATE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      step  <= '0;
      dig_h <= '0;
      dig_t <= '0;
      dig_o <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin   <= count_in;
            bcd   <= '0;
            step  <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adjust(bcd), bin} << 1;
          step       <= step + 3'd1;
          if (step == 3'(CONV_STEPS - 1)) state <= UPDATE;
        end
        UPDATE: begin
          dig_h <= bcd[11:8];
          dig_t <= bcd[7:4];
          dig_o <= bcd[3:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [15:0] div;
  logic        div_tc;
  digit_t      idx, idx_nxt;

  assign div_tc = (div == 16'(SCAN_DIV - 1));

  always_comb begin
    idx_nxt = idx;
    if (div_tc) begin
      case (idx)
        DIG_ONES: idx_nxt = DIG_TENS;
        DIG_TENS: idx_nxt = DIG_HUNDS;
        default:  idx_nxt = DIG_ONES;
      endcase
    end
  end

  // seg/an are registered from the upcoming index so both move on the same edge.
  logic [3:0] sel_digit;
  logic       sel_blank;
  logic [2:0] an_nxt;
  logic [6:0] pattern;

  always_comb begin
    sel_digit = dig_o;
    sel_blank = 1'b0;
    an_nxt    = 3'b001;
    case (idx_nxt)
      DIG_TENS: begin
        sel_digit = dig_t;
        sel_blank = (dig_h == 4'd0) && (dig_t == 4'd0);
        an_nxt    = 3'b010;
      end
      DIG_HUNDS: begin
        sel_digit = dig_h;
        sel_blank = (dig_h == 4'd0);
        an_nxt    = 3'b100;
      end
      default: ;
    endcase
  end

  seg7_decode u_dec (
    .digit   (sel_digit),
    .blank   (sel_blank),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div <= '0;
      idx <= DIG_ONES;
      an  <= 3'b001;
      seg <= SEG_RESET;
    end else begin
      div <= div_tc ? '0 : div + 16'd1;
      idx <= idx_nxt;
      an  <= an_nxt;
      seg <= SEG_ACTIVE_LOW ? ~pattern : pattern;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed and random checks of count_display_driver against a decimal-arithmetic model.
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] count_in = '0;
  logic       load = 1'b0;
  logic       busy, done, busy2, done2;
  logic [6:0] seg, seg2;
  logic [2:0] an, an2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  count_display_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .clr(clr), .count_in(count_in), .load(load),
    .busy(busy), .done(done), .seg(seg), .an(an)
  );

  count_display_driver #(.SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .clr(clr), .count_in(count_in), .load(load),
    .busy(busy2), .done(done2), .seg(seg2), .an(an2)
  );

  // Edges seen since reset release; the scan position follows from this alone.
  always @(posedge clk or negedge clr) begin
    if (!clr) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [6:0] font(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit(input int v, input int pos);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    if (pos == 2) return (h == 0) ? 7'b0 : font(h);
    if (pos == 1) return (h == 0 && t == 0) ? 7'b0 : font(t);
    return font(o);
  endfunction

  function automatic logic [2:0] exp_an(input int c, input int sd);
    return 3'b001 << ((c / sd) % 3);
  endfunction

  function automatic int an_pos(input logic [2:0] a);
    if (a == 3'b010) return 1;
    if (a == 3'b100) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("an_scan4", 32'(an), 32'(exp_an(cyc, 4)));
    chk("an_scan3", 32'(an2), 32'(exp_an(cyc, 3)));
  endtask

  task automatic check_display(input int v, input int n);
    logic [6:0] e;
    repeat (n) begin
      tick();
      e = ~ref_digit(v, an_pos(an));
      chk("seg_lo", 32'(seg), 32'(e));
      e = ref_digit(v, an_pos(an2));
      chk("seg_hi", 32'(seg2), 32'(e));
    end
  endtask

  task automatic run_conv(input logic [7:0] v, input int ign_at, input logic [7:0] ign_val);
    int nb, ndone;
    count_in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    count_in = 8'($urandom);
    nb = 0;
    ndone = 0;
    while (busy && nb < 20) begin
      if (nb == ign_at) begin
        load = 1'b1;
        count_in = ign_val;
      end
      if (done) ndone++;
      tick();
      load = 1'b0;
      nb++;
    end
    chk("busy_cycles", 32'(nb), 32'd9);
    chk("done_early", 32'(ndone), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_pulse_hi", 32'(done2), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    tick();
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    check_display(int'(v), 12);
  endtask

  initial begin
    int nb, ndone;
    logic [7:0] rv;

    #2 clr = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_an", 32'(an), 32'b001);
    chk("rst_seg_lo", 32'(seg), 32'h40);
    chk("rst_seg_hi", 32'(seg2), 32'h3F);
    tick();
    tick();
    clr = 1'b1;
    check_display(0, 14);

    run_conv(8'd255, -1, 8'd0);
    run_conv(8'd0, -1, 8'd0);
    run_conv(8'd100, -1, 8'd0);
    run_conv(8'd7, 2, 8'd42);
    run_conv(8'd9, -1, 8'd0);
    run_conv(8'd10, -1, 8'd0);
    run_conv(8'd99, -1, 8'd0);
    repeat (6) begin
      rv = 8'($urandom_range(0, 255));
      run_conv(rv, -1, 8'd0);
    end

    // Held load: restarts immediately after done, capturing the new value.
    count_in = 8'd128;
    load = 1'b1;
    tick();
    count_in = 8'd63;
    nb = 0;
    while (busy && nb < 20) begin
      tick();
      nb++;
    end
    chk("held_busy_cycles", 32'(nb), 32'd9);
    chk("held_done", 32'(done), 32'd1);
    tick();
    chk("held_restart", 32'(busy), 32'd1);
    load = 1'b0;
    check_display(128, 6);
    nb = 0;
    while (!done && nb < 20) begin
      tick();
      nb++;
    end
    chk("held_second_done", 32'(done), 32'd1);
    tick();
    check_display(63, 12);

    // Reset during CONV cycle 5 of converting 200.
    count_in = 8'd200;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    #2 clr = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_an", 32'(an), 32'b001);
    chk("abort_seg_lo", 32'(seg), 32'h40);
    chk("abort_seg_hi", 32'(seg2), 32'h3F);
    tick();
    tick();
    clr = 1'b1;
    ndone = 0;
    repeat (12) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    check_display(0, 12);
    run_conv(8'd200, -1, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
